// File: rtl/am2301_frame_decoder.sv
// Host-side transaction engine for AM2301/DHT-class single-wire sensors:
// wake-up pulse, acknowledge tracking, 40-bit pulse-width decode and checksum.
module am2301_frame_decoder #(
    parameter int CLK_PER_US     = 133,
    parameter int START_LOW_US   = 1000,
    parameter int BIT1_THRESH_US = 50,
    parameter int TIMEOUT_US     = 200
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset_n,
    input  logic        start,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        busy,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic        frame_valid,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam int              DIV_W     = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_PER_US - 1);
    localparam logic [15:0]     START_LOW = 16'(START_LOW_US);
    localparam logic [15:0]     THRESH    = 16'(BIT1_THRESH_US);
    localparam logic [15:0]     TIMEOUT   = 16'(TIMEOUT_US);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HOST_LOW = 3'd1,
        S_HOST_REL = 3'd2,
        S_ACK_LOW  = 3'd3,
        S_ACK_HIGH = 3'd4,
        S_BIT_LOW  = 3'd5,
        S_BIT_HIGH = 3'd6,
        S_CHECK    = 3'd7
    } state_t;

    function automatic logic checksum_ok(input logic [39:0] f);
        logic [7:0] sum;
        sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return (sum == f[7:0]);
    endfunction

    logic             r_sync1, r_sda_s, r_sda_d;
    logic [DIV_W-1:0] r_div;
    logic [15:0]      r_phase;
    state_t           r_state;
    logic [5:0]       r_bit_cnt;
    logic [39:0]      r_shift;
    logic             r_sda_oe, r_busy, r_fv, r_err;
    logic [15:0]      r_hum, r_temp;
    logic [1:0]       r_err_code;

    state_t           w_state_next;
    logic             w_rise, w_fall, w_tick, w_timeout, w_sum_ok, w_accept;
    logic             w_abort;
    logic [1:0]       w_abort_code;
    logic             w_sda_oe_next, w_busy_next, w_fv_next;

    assign w_rise    = r_sda_s & ~r_sda_d;
    assign w_fall    = ~r_sda_s & r_sda_d;
    assign w_tick    = (r_div == DIV_MAX);
    assign w_timeout = (r_phase > TIMEOUT);
    assign w_sum_ok  = checksum_ok(r_shift);
    assign w_accept  = (r_state == S_IDLE) && start;

    // Pad synchronizer and one-cycle delayed copy for edge detection; idles high like the bus
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_sync1 <= 1'b1;
            r_sda_s <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_sync1 <= sda_in;
            r_sda_s <= r_sync1;
            r_sda_d <= r_sda_s;
        end
    end

    // Free-running microsecond divider and per-state elapsed-time counter
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_div   <= '0;
            r_phase <= 16'd0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_state_next != r_state) begin
                r_phase <= 16'd0;
            end else if (w_tick && (r_phase != 16'hFFFF)) begin
                r_phase <= r_phase + 16'd1;
            end else begin
                r_phase <= r_phase;
            end
        end
    end

    // State register
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and abort decode; an edge always takes priority over a timeout
    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        w_abort_code = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_HOST_LOW;
                else       w_state_next = S_IDLE;
            end
            S_HOST_LOW: begin
                if (r_phase == START_LOW) w_state_next = S_HOST_REL;
                else                      w_state_next = S_HOST_LOW;
            end
            S_HOST_REL: begin
                if (w_fall) begin
                    w_state_next = S_ACK_LOW;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                    w_abort      = 1'b1;
                    w_abort_code = 2'd1;
                end else begin
                    w_state_next = S_HOST_REL;
                end
            end
            S_ACK_LOW, S_ACK_HIGH, S_BIT_LOW, S_BIT_HIGH: begin
                if ((r_state == S_ACK_LOW) && w_rise) begin
                    w_state_next = S_ACK_HIGH;
                end else if ((r_state == S_ACK_HIGH) && w_fall) begin
                    w_state_next = S_BIT_LOW;
                end else if ((r_state == S_BIT_LOW) && w_rise) begin
                    w_state_next = S_BIT_HIGH;
                end else if ((r_state == S_BIT_HIGH) && w_fall) begin
                    w_state_next = (r_bit_cnt == 6'd39) ? S_CHECK : S_BIT_LOW;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                    w_abort      = 1'b1;
                    w_abort_code = 2'd2;
                end else begin
                    w_state_next = r_state;
                end
            end
            S_CHECK: begin
                w_state_next = S_IDLE;
                if (!w_sum_ok) begin
                    w_abort      = 1'b1;
                    w_abort_code = 2'd3;
                end else begin
                    w_abort      = 1'b0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        w_sda_oe_next = (w_state_next == S_HOST_LOW);
        w_busy_next   = (w_state_next != S_IDLE);
        w_fv_next     = (r_state == S_CHECK) && w_sum_ok;
    end

    // Frame shift register and bit counter, cleared when a new transaction starts
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_shift   <= 40'd0;
            r_bit_cnt <= 6'd0;
        end else if (w_accept) begin
            r_shift   <= 40'd0;
            r_bit_cnt <= 6'd0;
        end else if ((r_state == S_BIT_HIGH) && w_fall) begin
            r_shift   <= {r_shift[38:0], (r_phase >= THRESH)};
            r_bit_cnt <= (r_bit_cnt == 6'd39) ? 6'd0 : r_bit_cnt + 6'd1;
        end else begin
            r_shift   <= r_shift;
            r_bit_cnt <= r_bit_cnt;
        end
    end

    // Registered host outputs, result latch and error reporting
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_fv       <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_hum      <= 16'd0;
            r_temp     <= 16'd0;
        end else begin
            r_sda_oe <= w_sda_oe_next;
            r_busy   <= w_busy_next;
            r_fv     <= w_fv_next;
            r_err    <= w_abort;
            if (w_accept)     r_err_code <= 2'd0;
            else if (w_abort) r_err_code <= w_abort_code;
            else              r_err_code <= r_err_code;
            if (w_fv_next) begin
                r_hum  <= r_shift[39:24];
                r_temp <= r_shift[23:8];
            end else begin
                r_hum  <= r_hum;
                r_temp <= r_temp;
            end
        end
    end

    assign sda_oe      = r_sda_oe;
    assign busy        = r_busy;
    assign humidity    = r_hum;
    assign temperature = r_temp;
    assign frame_valid = r_fv;
    assign error       = r_err;
    assign err_code    = r_err_code;

endmodule
